// File: rtl/cfo_ctrl_pkg.sv
// Shared definitions for the CFO estimator controller: default sizing,
// 3-bit state encoding and a width helper used for port and counter sizing.
package cfo_ctrl_pkg;

    localparam int WIN_LEN_DEF = 16;
    localparam int NUM_SEG_DEF = 4;
    localparam int CLR_CYC_DEF = 2;
    localparam int TMO_CYC_DEF = 64;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CLR  = 3'd1;
    localparam logic [2:0] ST_ACC  = 3'd2;
    localparam logic [2:0] ST_SEG  = 3'd3;
    localparam logic [2:0] ST_ATAN = 3'd4;
    localparam logic [2:0] ST_HOLD = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_CLR  = ST_CLR,
        S_ACC  = ST_ACC,
        S_SEG  = ST_SEG,
        S_ATAN = ST_ATAN,
        S_HOLD = ST_HOLD,
        S_DONE = ST_DONE
    } state_t;

    // Ceiling log2, never below 1 so a single-entry index still has one bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/cfo_win_counter.sv
// Window sample counter and segment index for the CFO estimator.
// Counts accepted samples within a window, flags the wrap on the last sample
// and advances the segment index on request. Clear has priority.
module cfo_win_counter
    import cfo_ctrl_pkg::*;
#(
    parameter int WIN_LEN = WIN_LEN_DEF,
    parameter int NUM_SEG = NUM_SEG_DEF
)(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clr,
    input  logic                        inc,
    input  logic                        seg_inc,
    output logic [clog2(NUM_SEG)-1:0]   seg,
    output logic                        wrap,
    output logic                        last_seg
);

    localparam int CNT_W = clog2(WIN_LEN);
    localparam int SEG_W = clog2(NUM_SEG);

    logic [CNT_W-1:0] cnt_r;
    logic [SEG_W-1:0] seg_r;

    assign wrap     = inc && (cnt_r == CNT_W'(WIN_LEN - 1));
    assign last_seg = (seg_r == SEG_W'(NUM_SEG - 1));
    assign seg      = seg_r;

    // Sample count within the current window; wraps to zero on the last sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc) begin
            if (wrap) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Segment index selecting the accumulator bank entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_r <= {SEG_W{1'b0}};
        end else if (clr) begin
            seg_r <= {SEG_W{1'b0}};
        end else if (seg_inc) begin
            seg_r <= seg_r + SEG_W'(1);
        end else begin
            seg_r <= seg_r;
        end
    end

endmodule

// File: rtl/cfo_est_ctrl_seg.sv
// CFO estimator control FSM: clears the datapath, accumulates WIN_LEN valid
// samples in each of NUM_SEG segments, launches the atan unit with a timeout,
// and holds the result under a ready/valid handshake. Outputs are decoded
// from the state register so an asynchronous reset drops them at once.
module cfo_est_ctrl_seg
    import cfo_ctrl_pkg::*;
#(
    parameter int WIN_LEN = WIN_LEN_DEF,
    parameter int NUM_SEG = NUM_SEG_DEF,
    parameter int CLR_CYC = CLR_CYC_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF
)(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        go,
    input  logic                        abort,
    input  logic                        s_valid,
    input  logic                        atan_done,
    input  logic                        res_ready,
    output logic                        mode,
    output logic                        cen,
    output logic                        cnt_rst,
    output logic                        reg_rst,
    output logic                        reg_ld,
    output logic [clog2(NUM_SEG)-1:0]   seg_sel,
    output logic                        atan_start,
    output logic                        t_valid,
    output logic                        done,
    output logic                        busy,
    output logic                        err
);

    localparam int CYC_MAX = (TMO_CYC > CLR_CYC) ? TMO_CYC : CLR_CYC;
    localparam int CYC_W   = clog2(CYC_MAX + 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CYC_W-1:0]   cyc_cnt_r;
    logic               err_r;
    logic               abort_take_s;
    logic               clr_last_s;
    logic               tmo_last_s;
    logic               win_clr_s;
    logic               win_inc_s;
    logic               seg_inc_s;
    logic               wrap_s;
    logic               last_seg_s;

    // Abort only cancels work that has not yet produced a result.
    assign abort_take_s = abort && ((state_r == S_CLR) || (state_r == S_ACC) ||
                                    (state_r == S_SEG) || (state_r == S_ATAN));
    assign clr_last_s   = (cyc_cnt_r == CYC_W'(CLR_CYC - 1));
    assign tmo_last_s   = (cyc_cnt_r == CYC_W'(TMO_CYC - 1));

    // The window bank returns to segment 0 on clear, on abort and on the way into DONE.
    assign win_clr_s = (state_r == S_CLR) || abort_take_s || (state_nxt_s == S_DONE);
    assign win_inc_s = (state_r == S_ACC) && s_valid && !abort;
    assign seg_inc_s = (state_r == S_SEG);

    cfo_win_counter #(
        .WIN_LEN (WIN_LEN),
        .NUM_SEG (NUM_SEG)
    ) u_win_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (win_clr_s),
        .inc      (win_inc_s),
        .seg_inc  (seg_inc_s),
        .seg      (seg_sel),
        .wrap     (wrap_s),
        .last_seg (last_seg_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Cycles spent in the current state; only CLR and ATAN are timed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_cnt_r <= {CYC_W{1'b0}};
        end else if (state_nxt_s != state_r) begin
            cyc_cnt_r <= {CYC_W{1'b0}};
        end else if ((state_r == S_CLR) || (state_r == S_ATAN)) begin
            cyc_cnt_r <= cyc_cnt_r + CYC_W'(1);
        end else begin
            cyc_cnt_r <= {CYC_W{1'b0}};
        end
    end

    // Sticky atan-timeout flag, cleared when a new estimate is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_r <= 1'b0;
        end else if ((state_r == S_IDLE) && go) begin
            err_r <= 1'b0;
        end else if ((state_r == S_ATAN) && (state_nxt_s == S_DONE)) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Next-state selection; abort takes priority over progress in cancellable states.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (go) begin
                    state_nxt_s = S_CLR;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_CLR: begin
                if (abort) begin
                    state_nxt_s = S_IDLE;
                end else if (clr_last_s) begin
                    state_nxt_s = S_ACC;
                end else begin
                    state_nxt_s = S_CLR;
                end
            end
            S_ACC: begin
                if (abort) begin
                    state_nxt_s = S_IDLE;
                end else if (wrap_s && last_seg_s) begin
                    state_nxt_s = S_ATAN;
                end else if (wrap_s) begin
                    state_nxt_s = S_SEG;
                end else begin
                    state_nxt_s = S_ACC;
                end
            end
            S_SEG: begin
                if (abort) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_ACC;
                end
            end
            S_ATAN: begin
                if (abort) begin
                    state_nxt_s = S_IDLE;
                end else if (atan_done) begin
                    state_nxt_s = S_HOLD;
                end else if (tmo_last_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_ATAN;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_HOLD;
                end
            end
            S_DONE: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Output decode; abort turns the current cycle into a datapath clear.
    always_comb begin
        mode       = 1'b0;
        cen        = 1'b0;
        cnt_rst    = 1'b0;
        reg_rst    = 1'b0;
        reg_ld     = 1'b0;
        atan_start = 1'b0;
        t_valid    = 1'b0;
        done       = 1'b0;
        case (state_r)
            S_IDLE: begin
                mode = 1'b0;
            end
            S_CLR: begin
                mode    = 1'b1;
                cnt_rst = 1'b1;
                reg_rst = 1'b1;
            end
            S_ACC: begin
                mode   = 1'b1;
                cen    = s_valid && !abort;
                reg_ld = s_valid && !abort;
            end
            S_SEG: begin
                mode    = 1'b1;
                cnt_rst = 1'b1;
            end
            S_ATAN: begin
                atan_start = (cyc_cnt_r == {CYC_W{1'b0}}) && !abort;
            end
            S_HOLD: begin
                t_valid = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                mode = 1'b0;
            end
        endcase
        cnt_rst = cnt_rst || abort_take_s;
        reg_rst = reg_rst || abort_take_s;
    end

    assign busy = (state_r != S_IDLE);
    assign err  = err_r;

endmodule
